// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared opcodes and FSM encoding for the memory-stage controller
package mem_access_ctrl_pkg;

  localparam logic [3:0] OPC_LW = 4'b1000;
  localparam logic [3:0] OPC_SW = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_mem_op(input logic [3:0] opc);
    return (opc == OPC_LW) || (opc == OPC_SW);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_sat_counter.sv
// rtl/mem_access_ctrl_sat_counter.sv - clearable up-counter that holds at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage LW/SW sequencer against a variable-latency data memory
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr,
  input  logic [15:0]      alu_result,
  input  logic [15:0]      dataIn,
  input  logic [3:0]       dstReg,
  output logic             mem_req,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_ack,
  output logic             stall_en,
  output logic [15:0]      wb_data,
  output logic [3:0]       wb_dst,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [15:0]   data_q;
  logic [TW-1:0] to_cnt;
  logic [3:0]    opcode;
  logic          is_mem;
  logic          is_sw;
  logic          to_hit;
  logic          unused_instr_bits;

  assign opcode            = instr[15:12];
  assign is_mem            = is_mem_op(opcode);
  assign is_sw             = (opcode == OPC_SW);
  assign to_hit            = (to_cnt == TO_LAST);
  assign unused_instr_bits = ^instr[11:0];

  // Address/data/direction come straight from EX/MEM, which is frozen while stalled.
  assign mem_addr  = {alu_result[15:1], 1'b0};
  assign mem_wdata = dataIn;
  assign mem_we    = is_sw;
  assign wb_dst    = dstReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      data_q  <= '0;
      to_cnt  <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: to_cnt <= '0;
        ST_WAIT: begin
          to_cnt <= to_cnt + TW'(1);
          // An ack on the last allowed cycle still counts as a successful access.
          if (mem_ack) begin
            data_q <= is_sw ? 16'h0000 : mem_rdata;
          end else if (to_hit) begin
            data_q  <= 16'h0000;
            mem_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    stall_en  = 1'b0;
    mem_req   = 1'b0;
    wb_data   = alu_result;
    case (state)
      ST_IDLE: begin
        if (is_mem) begin
          stall_en  = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_en = 1'b1;
        mem_req  = 1'b1;
        if (mem_ack || to_hit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        wb_data   = data_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (stall_en),
    .cnt (stall_cnt)
  );

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory-stage controller that consumes the EX/MEM pipeline register outputs (instr, alu_result, dataIn, dstReg) and performs LW/SW against a variable-latency data memory. It is the producer of the stall_en signal that freezes the EX/MEM register (and all upstream registers) while an access is outstanding. It also produces the write-back value for the MEM/WB register.

Parameters:
TIMEOUT, 16, max cycles to wait for mem_ack before abandoning the access (must be >= 2)
CNT_W, 16, width of the saturating stall-cycle performance counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
instr  input  16  instruction from EX/MEM; opcode = instr[15:12]
alu_result  input  16  effective byte address for LW/SW, or ALU result otherwise
dataIn  input  16  store data for SW
dstReg  input  4  destination register from EX/MEM
mem_req  output  1  memory request, held high until mem_ack
mem_we  output  1  1 = write (SW), 0 = read (LW); valid while mem_req
mem_addr  output  16  word-aligned address {alu_result[15:1],1'b0}
mem_wdata  output  16  store data, equals dataIn
mem_rdata  input  16  read data, valid in the cycle mem_ack is high
mem_ack  input  1  single-cycle completion pulse from memory
stall_en  output  1  freezes EX/MEM and upstream pipeline registers
wb_data  output  16  value for MEM/WB (load data or alu_result)
wb_dst  output  4  equals dstReg
mem_err  output  1  sticky: set on timeout, cleared only by rst
stall_cnt  output  CNT_W  saturating count of cycles with stall_en high

Behaviour:
- Opcodes: LW = 4'b1000, SW = 4'b1001; every other opcode is non-memory.
- States: IDLE, WAIT, DONE. Reset -> IDLE, mem_err=0, stall_cnt=0, captured data reg=0, timeout counter=0.
- IDLE, non-memory opcode: stall_en=0, mem_req=0, wb_data=alu_result (combinational). Stay IDLE.
- IDLE, LW/SW: stall_en=1 combinationally in the same cycle; next state WAIT; timeout counter cleared.
- WAIT: mem_req=1, stall_en=1, mem_we=(opcode==SW). Counter increments each cycle.
  - mem_ack=1: capture mem_rdata (LW) or 0 (SW) into the data reg; go to DONE.
  - no ack and counter==TIMEOUT-1: set mem_err, capture 16'h0000, go to DONE; a later stray mem_ack is ignored.
- DONE: exactly one cycle; stall_en=0, mem_req=0, wb_data=captured reg; the pipeline advances at the end of this cycle. Next state IDLE unconditionally, so the next instruction is evaluated fresh (back-to-back LWs each take a full IDLE->WAIT->DONE sequence).
- Minimum memory-op latency: mem_ack in the first WAIT cycle gives stall_en high for 2 cycles (IDLE, WAIT), then DONE.
- mem_ack while in IDLE or DONE: ignored.
- mem_addr, mem_wdata and mem_we are driven combinationally from inputs. They are stable during WAIT because stall_en freezes EX/MEM.
- Bit 0 of alu_result is dropped. There is no misalignment error.
- wb_dst = dstReg at all times.
- stall_cnt increments on each cycle with stall_en=1 and saturates at all-ones.
- rst mid-access (WAIT): next cycle IDLE, mem_req=0, stall_en follows IDLE rules; mem_err and stall_cnt are cleared.

Decomposition:
- Shared package constants: OPC_LW, OPC_SW, and state encodings IDLE/WAIT/DONE (2-bit).
- One sub-module, sat_counter (parameterised width, inc, clr), instantiated for stall_cnt. The timeout counter is inline.

Test Plan:
- Reset, then ADD instr with alu_result=16'h1234 -> stall_en=0, mem_req=0, wb_data=16'h1234, stall_cnt=0.
- LW alu_result=16'h0041, mem_ack after 3 WAIT cycles with mem_rdata=16'hBEEF -> mem_addr=16'h0040, stall_en high 4 cycles, DONE wb_data=16'hBEEF, stall_cnt=4.
- SW alu_result=16'h0010, dataIn=16'hA5A5, ack in first WAIT cycle -> mem_we=1, mem_wdata=16'hA5A5, stall 2 cycles, wb_data=0.
- LW with no ack, TIMEOUT=16 -> mem_err=1 after 16 WAIT cycles, wb_data=0 in DONE, later mem_ack ignored, mem_err stays 1.
- Two back-to-back LWs (ack latency 1, data 16'h0001 then 16'h0002) -> two distinct mem_req bursts separated by DONE, wb_data 1 then 2.
- rst asserted in 2nd WAIT cycle -> next cycle IDLE, mem_req=0, mem_err=0, stall_cnt=0.
